// File: rtl/cv32e40s_pma_prog.sv
// ============================================================================
// Module   : cv32e40s_pma_prog
// Purpose  : Run-time programmable, multi-channel PMA checker. Software fills
//            a table of address regions through a config port (with a sticky
//            per-region lock). NUM_CH independent requesters each get a
//            registered, one-cycle attribute lookup. A saturating counter
//            tracks how many erroneous responses have been returned.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            cfg_we_i/idx/field/wdata - table write port
//            cfg_err_o                - pulse: previous write was rejected
//            req_i, addr_i, qualifiers- per-channel lookup request
//            rvalid_o + attributes    - per-channel registered response
//            err_cnt_clr_i/err_cnt_o  - saturating error counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40s_pma_prog #(
  parameter int PMA_NUM_REGIONS = 4,
  parameter int NUM_CH          = 2,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we_i,
  input  logic [3:0]             cfg_idx_i,
  input  logic [1:0]             cfg_field_i,
  input  logic [31:0]            cfg_wdata_i,
  output logic                   cfg_err_o,
  input  logic [NUM_CH-1:0]      req_i,
  input  logic [32*NUM_CH-1:0]   addr_i,
  input  logic [NUM_CH-1:0]      instr_i,
  input  logic [NUM_CH-1:0]      load_i,
  input  logic [NUM_CH-1:0]      misaligned_i,
  input  logic [NUM_CH-1:0]      modified_i,
  input  logic [NUM_CH-1:0]      pushpop_i,
  input  logic [NUM_CH-1:0]      dbg_region_i,
  output logic [NUM_CH-1:0]      rvalid_o,
  output logic [NUM_CH-1:0]      err_o,
  output logic [NUM_CH-1:0]      integrity_o,
  output logic [NUM_CH-1:0]      bufferable_o,
  output logic [NUM_CH-1:0]      cacheable_o,
  output logic [NUM_CH-1:0]      hit_o,
  output logic [4*NUM_CH-1:0]    region_o,
  input  logic                   err_cnt_clr_i,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  localparam logic [1:0] c_FIELD_LOW  = 2'b00;
  localparam logic [1:0] c_FIELD_HIGH = 2'b01;
  localparam logic [1:0] c_FIELD_ATTR = 2'b10;
  localparam logic [1:0] c_FIELD_RSVD = 2'b11;
  // Headroom so a full-count plus up to NUM_CH increments cannot wrap.
  localparam int         c_SUM_W      = ERR_CNT_W + 3;

  // Region table. attr_q holds {integrity, cacheable, bufferable, main, enable};
  // the lock bit is kept separately and attr bits 6:5 are simply not stored.
  logic [29:0] low_q  [PMA_NUM_REGIONS];
  logic [29:0] high_q [PMA_NUM_REGIONS];
  logic [4:0]  attr_q [PMA_NUM_REGIONS];
  logic        lock_q [PMA_NUM_REGIONS];
  logic        cfg_err_q;

  logic        idx_ok;
  logic        locked;
  logic        cfg_reject;
  logic        cfg_accept;

  always_comb begin
    idx_ok = ({1'b0, cfg_idx_i} < 5'(PMA_NUM_REGIONS));
    locked = 1'b0;
    for (int i = 0; i < PMA_NUM_REGIONS; i++) begin
      if (cfg_idx_i == 4'(i)) locked = lock_q[i];
    end
    cfg_reject = !idx_ok || (cfg_field_i == c_FIELD_RSVD) || locked;
    cfg_accept = cfg_we_i && !cfg_reject;
  end

  // Lock can only be set here: any write to a locked entry is rejected, so
  // nothing but rst ever clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PMA_NUM_REGIONS; i++) begin
        low_q[i]  <= '0;
        high_q[i] <= '0;
        attr_q[i] <= '0;
        lock_q[i] <= 1'b0;
      end
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we_i && cfg_reject;
      for (int i = 0; i < PMA_NUM_REGIONS; i++) begin
        if (cfg_accept && (cfg_idx_i == 4'(i))) begin
          case (cfg_field_i)
            c_FIELD_LOW:  low_q[i]  <= cfg_wdata_i[29:0];
            c_FIELD_HIGH: high_q[i] <= cfg_wdata_i[29:0];
            c_FIELD_ATTR: begin
              attr_q[i] <= cfg_wdata_i[4:0];
              lock_q[i] <= cfg_wdata_i[7];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Per-channel lookup against the table state at the start of the cycle.
  logic [29:0]       waddr    [NUM_CH];
  logic [3:0]        region_d [NUM_CH];
  logic [NUM_CH-1:0] hit_d;
  logic [NUM_CH-1:0] main_d;
  logic [NUM_CH-1:0] integ_sel;
  logic [NUM_CH-1:0] cach_sel;
  logic [NUM_CH-1:0] buf_sel;
  logic [NUM_CH-1:0] err_d;
  logic [NUM_CH-1:0] buf_d;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      waddr[c]     = addr_i[32*c+2 +: 30];
      hit_d[c]     = 1'b0;
      region_d[c]  = 4'd0;
      main_d[c]    = 1'b0;
      integ_sel[c] = 1'b0;
      cach_sel[c]  = 1'b0;
      buf_sel[c]   = 1'b0;
      // Scan downwards so the lowest-index match is the last one written.
      for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
        if (attr_q[i][0] && (low_q[i] <= waddr[c]) && (waddr[c] < high_q[i])) begin
          hit_d[c]     = 1'b1;
          region_d[c]  = 4'(i);
          main_d[c]    = attr_q[i][1];
          buf_sel[c]   = attr_q[i][2];
          cach_sel[c]  = attr_q[i][3];
          integ_sel[c] = attr_q[i][4];
        end
      end
      if (dbg_region_i[c]) begin
        hit_d[c]     = 1'b0;
        region_d[c]  = 4'd0;
        main_d[c]    = 1'b1;
        buf_sel[c]   = 1'b0;
        cach_sel[c]  = 1'b0;
        integ_sel[c] = 1'b0;
      end
      err_d[c] = !main_d[c] &&
                 (instr_i[c] || misaligned_i[c] || modified_i[c] || pushpop_i[c]);
      buf_d[c] = buf_sel[c] && !instr_i[c] && !load_i[c];
    end
  end

  logic [NUM_CH-1:0]   rvalid_q;
  logic [NUM_CH-1:0]   err_q;
  logic [NUM_CH-1:0]   integ_q;
  logic [NUM_CH-1:0]   buf_q;
  logic [NUM_CH-1:0]   cach_q;
  logic [NUM_CH-1:0]   hit_q;
  logic [4*NUM_CH-1:0] region_q;

  // Attributes are gated with the request so idle channels present zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      err_q    <= '0;
      integ_q  <= '0;
      buf_q    <= '0;
      cach_q   <= '0;
      hit_q    <= '0;
      region_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rvalid_q[c]         <= req_i[c];
        err_q[c]            <= req_i[c] && err_d[c];
        integ_q[c]          <= req_i[c] && integ_sel[c];
        buf_q[c]            <= req_i[c] && buf_d[c];
        cach_q[c]           <= req_i[c] && cach_sel[c];
        hit_q[c]            <= req_i[c] && hit_d[c];
        region_q[4*c +: 4]  <= req_i[c] ? region_d[c] : 4'd0;
      end
    end
  end

  // Saturating error counter fed by the responses currently on the outputs.
  logic [c_SUM_W-1:0]   err_inc;
  logic [c_SUM_W-1:0]   err_sum;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  always_comb begin
    err_inc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      err_inc = err_inc + c_SUM_W'(rvalid_q[c] && err_q[c]);
    end
    err_sum = c_SUM_W'(err_cnt_q) + err_inc;
    if (err_cnt_clr_i)                        err_cnt_d = '0;
    else if (|err_sum[c_SUM_W-1:ERR_CNT_W])   err_cnt_d = '1;
    else                                      err_cnt_d = err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  // Byte offset bits and the top of the write data carry no meaning here.
  logic unused_bits;
  always_comb begin
    unused_bits = ^cfg_wdata_i[31:30];
    for (int c = 0; c < NUM_CH; c++) begin
      unused_bits = unused_bits ^ (^addr_i[32*c +: 2]);
    end
  end

  assign cfg_err_o    = cfg_err_q;
  assign rvalid_o     = rvalid_q;
  assign err_o        = err_q;
  assign integrity_o  = integ_q;
  assign bufferable_o = buf_q;
  assign cacheable_o  = cach_q;
  assign hit_o        = hit_q;
  assign region_o     = region_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40s_pma_prog.sv
// ============================================================================
// Module   : tb_cv32e40s_pma_prog
// Purpose  : Self-checking bench for cv32e40s_pma_prog (4 regions, 2 channels,
//            4-bit error counter). Expected responses are queued per channel
//            when a request is driven and compared when the response is due.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40s_pma_prog;

  localparam int NCH = 2;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [3:0]     cfg_idx = '0;
  logic [1:0]     cfg_field = '0;
  logic [31:0]    cfg_wdata = '0;
  logic           cfg_err_o;
  logic [NCH-1:0] req = '0;
  logic [63:0]    addr = '0;
  logic [NCH-1:0] instr = '0, load = '0, mis = '0, modf = '0, pp = '0, dbg = '0;
  logic [NCH-1:0] rvalid_o, err_o, integrity_o, bufferable_o, cacheable_o, hit_o;
  logic [4*NCH-1:0] region_o;
  logic           clr = 1'b0;
  logic [CW-1:0]  err_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] cyc_n = '0;
  bit mon_en = 1'b0;

  cv32e40s_pma_prog #(.PMA_NUM_REGIONS(4), .NUM_CH(NCH), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata), .cfg_err_o(cfg_err_o),
    .req_i(req), .addr_i(addr), .instr_i(instr), .load_i(load),
    .misaligned_i(mis), .modified_i(modf), .pushpop_i(pp), .dbg_region_i(dbg),
    .rvalid_o(rvalid_o), .err_o(err_o), .integrity_o(integrity_o),
    .bufferable_o(bufferable_o), .cacheable_o(cacheable_o), .hit_o(hit_o),
    .region_o(region_o), .err_cnt_clr_i(clr), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- reference model of the region table ----------------
  logic [29:0] m_low  [4];
  logic [29:0] m_high [4];
  logic [7:0]  m_attr [4];

  typedef struct packed {
    logic [31:0] due;
    logic        err, integ, bufb, cach, hit;
    logic [3:0]  region;
  } resp_t;

  resp_t q0[$];
  resp_t q1[$];

  function automatic resp_t model(input logic [31:0] a, input logic f_instr, f_load,
                                  f_mis, f_mod, f_pp, f_dbg);
    resp_t r;
    logic found, mn, ig, ca, bu;
    int idx;
    logic [29:0] wa;
    wa = a[31:2];
    found = 1'b0; idx = 0;
    for (int i = 0; i < 4; i++)
      if (!found && m_attr[i][0] && m_low[i] <= wa && wa < m_high[i]) begin
        found = 1'b1; idx = i;
      end
    r = '0;
    if (f_dbg) begin
      mn = 1'b1; ig = 1'b0; ca = 1'b0; bu = 1'b0;
    end else if (found) begin
      mn = m_attr[idx][1]; bu = m_attr[idx][2]; ca = m_attr[idx][3]; ig = m_attr[idx][4];
      r.hit = 1'b1; r.region = 4'(idx);
    end else begin
      mn = 1'b0; ig = 1'b0; ca = 1'b0; bu = 1'b0;
    end
    r.err   = !mn && (f_instr || f_mis || f_mod || f_pp);
    r.integ = ig;
    r.cach  = ca;
    r.bufb  = bu && !f_instr && !f_load;
    return r;
  endfunction

  function automatic logic model_reject(input logic [3:0] idx, input logic [1:0] fld);
    if (idx >= 4'd4 || fld == 2'b11) return 1'b1;
    return m_attr[idx[1:0]][7];
  endfunction

  // One clock of stimulus: queue expected responses, then update the model
  // after the edge so same-cycle lookups see the old table.
  task automatic tick();
    resp_t e;
    logic rej;
    for (int c = 0; c < NCH; c++) begin
      if (req[c] && !rst) begin
        e = model(addr[32*c +: 32], instr[c], load[c], mis[c], modf[c], pp[c], dbg[c]);
        e.due = cyc_n + 1;
        if (c == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    rej = model_reject(cfg_idx, cfg_field);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_low[i] = '0; m_high[i] = '0; m_attr[i] = '0; end
    end else if (cfg_we && !rej) begin
      case (cfg_field)
        2'b00:   m_low[cfg_idx[1:0]]  = cfg_wdata[29:0];
        2'b01:   m_high[cfg_idx[1:0]] = cfg_wdata[29:0];
        default: m_attr[cfg_idx[1:0]] = cfg_wdata[7:0] & 8'h9F;
      endcase
    end
    #1;
    req = '0; cfg_we = 1'b0; clr = 1'b0;
    instr = '0; load = '0; mis = '0; modf = '0; pp = '0; dbg = '0;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [1:0] fld, input logic [31:0] wd);
    cfg_we = 1'b1; cfg_idx = idx; cfg_field = fld; cfg_wdata = wd;
    tick();
  endtask

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin : mon
    resp_t e;
    bit have;
    logic [8:0] act, expv;
    if (mon_en) begin
      for (int c = 0; c < NCH; c++) begin
        have = 1'b0;
        e = '0;
        if (c == 0 && q0.size() > 0 && q0[0].due == cyc_n) begin e = q0.pop_front(); have = 1'b1; end
        if (c == 1 && q1.size() > 0 && q1[0].due == cyc_n) begin e = q1.pop_front(); have = 1'b1; end
        act  = {err_o[c], integrity_o[c], bufferable_o[c], cacheable_o[c], hit_o[c], region_o[4*c +: 4]};
        expv = have ? {e.err, e.integ, e.bufb, e.cach, e.hit, e.region} : 9'd0;
        checks++;
        if (rvalid_o[c] !== have || act !== expv) begin
          errors++;
          $display("FAIL resp ch%0d cyc %0d: rvalid=%b {err,int,buf,cach,hit,reg}=%b required rvalid=%b attrs=%b",
                   c, cyc_n, rvalid_o[c], act, have, expv);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({rvalid_o, err_o, integrity_o, bufferable_o, cacheable_o, hit_o, region_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero response outputs, required 0");
    end
    checks++;
    if (err_cnt_o !== 4'd0 || cfg_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: err_cnt=%0d cfg_err=%b required 0 0", err_cnt_o, cfg_err_o);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    cfg_write(0, 2'b00, 32'h0); cfg_write(0, 2'b01, 32'h1000); cfg_write(0, 2'b10, 32'h03);
    req = 2'b01; addr[31:0] = 32'h0000_0FFC; instr = 2'b01; tick();
    checks++;
    if (rvalid_o[0] !== 1'b1 || hit_o[0] !== 1'b1 || region_o[3:0] !== 4'd0 || err_o[0] !== 1'b0) begin
      errors++; $display("FAIL basic_hit: rvalid=%b hit=%b region=%0d err=%b required 1 1 0 0",
                         rvalid_o[0], hit_o[0], region_o[3:0], err_o[0]);
    end
    req = 2'b01; addr[31:0] = 32'h0000_4000; instr = 2'b01; tick();
    checks++;
    if (hit_o[0] !== 1'b0 || err_o[0] !== 1'b1) begin
      errors++; $display("FAIL basic_miss: hit=%b err=%b required 0 1", hit_o[0], err_o[0]);
    end
    tick();
    checks++;
    if (err_cnt_o !== 4'd1) begin
      errors++; $display("FAIL basic_cnt: err_cnt=%0d required 1", err_cnt_o);
    end
  endtask

  task automatic test_priority();
    cfg_write(0, 2'b00, 32'h100); cfg_write(0, 2'b01, 32'h200); cfg_write(0, 2'b10, 32'h01);
    cfg_write(1, 2'b00, 32'h000); cfg_write(1, 2'b01, 32'h400); cfg_write(1, 2'b10, 32'h03);
    req = 2'b11; addr = {32'h500, 32'h800}; load = 2'b10; instr = 2'b01; tick();
    checks++;
    if (region_o[7:4] !== 4'd0 || hit_o[1] !== 1'b1 || err_o[1] !== 1'b0) begin
      errors++; $display("FAIL prio_ch1: region=%0d hit=%b err=%b required 0 1 0",
                         region_o[7:4], hit_o[1], err_o[1]);
    end
    checks++;
    if (region_o[3:0] !== 4'd1 || err_o[0] !== 1'b0) begin
      errors++; $display("FAIL prio_ch0: region=%0d err=%b required 1 0", region_o[3:0], err_o[0]);
    end
    req = 2'b10; addr[63:32] = 32'h500; load = 2'b10; mis = 2'b10; tick();
    checks++;
    if (err_o[1] !== 1'b1) begin
      errors++; $display("FAIL prio_misaligned: err=%b required 1", err_o[1]);
    end
  endtask

  task automatic test_lock();
    cfg_write(2, 2'b00, 32'h800); cfg_write(2, 2'b01, 32'h900); cfg_write(2, 2'b10, 32'hE3);
    checks++;
    if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL lock_set: cfg_err=%b required 0", cfg_err_o); end
    cfg_write(2, 2'b00, 32'h880);
    checks++;
    if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL lock_reject: cfg_err=%b required 1", cfg_err_o); end
    tick();
    checks++;
    if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL lock_pulse: cfg_err=%b required 0", cfg_err_o); end
    cfg_write(7, 2'b00, 32'h0);
    checks++;
    if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL idx_range: cfg_err=%b required 1", cfg_err_o); end
    cfg_write(0, 2'b11, 32'h0);
    checks++;
    if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL field_rsvd: cfg_err=%b required 1", cfg_err_o); end
    cfg_write(2, 2'b10, 32'h00);
    checks++;
    if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL lock_sticky: cfg_err=%b required 1", cfg_err_o); end
    req = 2'b01; addr[31:0] = 32'h2040; load = 2'b01; tick();
    checks++;
    if (hit_o[0] !== 1'b1 || region_o[3:0] !== 4'd2) begin
      errors++; $display("FAIL lock_low_kept: hit=%b region=%0d required 1 2", hit_o[0], region_o[3:0]);
    end
  endtask

  task automatic test_same_cycle();
    cfg_write(1, 2'b10, 32'h00);
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 2'b10; cfg_wdata = 32'h0;
    req = 2'b01; addr[31:0] = 32'h400; load = 2'b01; tick();
    checks++;
    if (hit_o[0] !== 1'b1 || region_o[3:0] !== 4'd0) begin
      errors++; $display("FAIL same_cycle_old: hit=%b region=%0d required 1 0", hit_o[0], region_o[3:0]);
    end
    req = 2'b01; addr[31:0] = 32'h400; load = 2'b01; tick();
    checks++;
    if (hit_o[0] !== 1'b0) begin errors++; $display("FAIL same_cycle_new: hit=%b required 0", hit_o[0]); end
  endtask

  task automatic test_dbg_buf();
    req = 2'b01; addr[31:0] = 32'h4000_0000; dbg = 2'b01; mis = 2'b01; tick();
    checks++;
    if (err_o[0] !== 1'b0 || bufferable_o[0] !== 1'b0 || hit_o[0] !== 1'b0) begin
      errors++; $display("FAIL dbg_override: err=%b buf=%b hit=%b required 0 0 0",
                         err_o[0], bufferable_o[0], hit_o[0]);
    end
    cfg_write(3, 2'b00, 32'h1000); cfg_write(3, 2'b01, 32'h1100); cfg_write(3, 2'b10, 32'h07);
    req = 2'b11; addr = {32'h4000_0000, 32'h4000}; pp = 2'b10; tick();
    checks++;
    if (bufferable_o[0] !== 1'b1 || region_o[3:0] !== 4'd3) begin
      errors++; $display("FAIL buf_store: buf=%b region=%0d required 1 3", bufferable_o[0], region_o[3:0]);
    end
    checks++;
    if (err_o[1] !== 1'b1) begin errors++; $display("FAIL pushpop_err: err=%b required 1", err_o[1]); end
    req = 2'b01; addr[31:0] = 32'h4000; load = 2'b01; tick();
    checks++;
    if (bufferable_o[0] !== 1'b0) begin errors++; $display("FAIL buf_load: buf=%b required 0", bufferable_o[0]); end
  endtask

  task automatic test_counter();
    clr = 1'b1; tick(); tick();
    checks++;
    if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL cnt_clear: err_cnt=%0d required 0", err_cnt_o); end
    for (int k = 0; k < 7; k++) begin
      req = 2'b11; addr = {32'h4000_0000, 32'h4000_0000}; instr = 2'b11; tick();
    end
    tick();
    checks++;
    if (err_cnt_o !== 4'd14) begin errors++; $display("FAIL cnt_14: err_cnt=%0d required 14", err_cnt_o); end
    req = 2'b11; instr = 2'b11; tick();
    req = 2'b11; instr = 2'b11; tick();
    checks++;
    if (err_cnt_o !== 4'd15) begin errors++; $display("FAIL cnt_sat: err_cnt=%0d required 15", err_cnt_o); end
    tick();
    checks++;
    if (err_cnt_o !== 4'd15) begin errors++; $display("FAIL cnt_hold: err_cnt=%0d required 15", err_cnt_o); end
    req = 2'b11; instr = 2'b11; tick();
    clr = 1'b1; tick();
    checks++;
    if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL cnt_clr_prio: err_cnt=%0d required 0", err_cnt_o); end
    tick();
    checks++;
    if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL cnt_clr_hold: err_cnt=%0d required 0", err_cnt_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [6];
    pool[0] = 32'h400; pool[1] = 32'h500; pool[2] = 32'h2040;
    pool[3] = 32'h4000; pool[4] = 32'h4000_0000; pool[5] = 32'h43FC;
    for (int k = 0; k < 24; k++) begin
      req   = 2'($urandom);
      addr  = {pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)]};
      instr = 2'($urandom); load = 2'($urandom); mis = 2'($urandom);
      modf  = 2'($urandom); pp = 2'($urandom); dbg = 2'($urandom_range(0, 3) == 0 ? 1 : 0);
      tick();
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req = 2'b11; addr = {32'h4000, 32'h2040}; load = 2'b11; tick();
    rst = 1'b1; req = 2'b11; addr = {32'h4000, 32'h2040}; instr = 2'b11; tick();
    checks++;
    if (rvalid_o !== 2'b00 || err_cnt_o !== 4'd0) begin
      errors++; $display("FAIL rst_mid: rvalid=%b err_cnt=%0d required 00 0", rvalid_o, err_cnt_o);
    end
    rst = 1'b0;
    req = 2'b01; addr[31:0] = 32'h2040; load = 2'b01; tick();
    checks++;
    if (rvalid_o[0] !== 1'b1 || hit_o[0] !== 1'b0) begin
      errors++; $display("FAIL rst_table: rvalid=%b hit=%b required 1 0", rvalid_o[0], hit_o[0]);
    end
    cfg_write(2, 2'b00, 32'h5);
    checks++;
    if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL rst_unlock: cfg_err=%b required 0", cfg_err_o); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_low[i] = '0; m_high[i] = '0; m_attr[i] = '0; end
    test_reset();
    test_basic();
    test_priority();
    test_lock();
    test_same_cycle();
    test_dbg_buf();
    test_counter();
    test_back_to_back();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL leftover: %0d/%0d responses never seen, required 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
